// File: rtl/rs_issue_queue.sv
// rs_issue_queue: reservation station for one functional unit.
// Holds dispatched ops until both operands are known and issues the
// oldest ready entry. Waiting entries snoop the per-ROB-tag result vector.
module rs_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int OP_W   = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OP_W-1:0]               in_op,
    input  logic                          in_src1_valid,
    input  logic                          in_src2_valid,
    input  logic [TAG_W-1:0]              in_src1_tag,
    input  logic [TAG_W-1:0]              in_src2_tag,
    input  logic [DATA_W-1:0]             in_src1_data,
    input  logic [DATA_W-1:0]             in_src2_data,
    input  logic [TAG_W-1:0]              in_rd_tag,
    input  logic [(2**TAG_W)-1:0]         rob_ready,
    input  logic [(2**TAG_W)*DATA_W-1:0]  rob_data,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [OP_W-1:0]               issue_op,
    output logic [DATA_W-1:0]             issue_src1,
    output logic [DATA_W-1:0]             issue_src2,
    output logic [TAG_W-1:0]              issue_tag,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy,
    output logic                          empty
);

    localparam int ROB_SIZE = 2**TAG_W;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int AGE_W    = $clog2(DEPTH);
    localparam int OCC_W    = $clog2(DEPTH+1);

    logic              busy    [DEPTH];
    logic [OP_W-1:0]   op      [DEPTH];
    logic [TAG_W-1:0]  rd_tag  [DEPTH];
    logic              s1_valid[DEPTH];
    logic [TAG_W-1:0]  s1_tag  [DEPTH];
    logic [DATA_W-1:0] s1_data [DEPTH];
    logic              s2_valid[DEPTH];
    logic [TAG_W-1:0]  s2_tag  [DEPTH];
    logic [DATA_W-1:0] s2_data [DEPTH];
    logic [AGE_W-1:0]  age     [DEPTH];

    logic [DATA_W-1:0] rob_word[ROB_SIZE];
    logic [DEPTH-1:0]  ready;
    logic              any_free;
    logic [IDX_W-1:0]  alloc_idx;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [AGE_W-1:0]  sel_age;
    logic              alloc;
    logic              fire;

    // Split the flat result bus into one word per ROB tag
    always_comb begin
        for (int t = 0; t < ROB_SIZE; t++) begin
            rob_word[t] = rob_data[t*DATA_W +: DATA_W];
        end
    end

    // Lowest-index free slot and per-entry readiness (stored or snooped operands)
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        ready     = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!busy[i]) begin
                any_free  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
            ready[i] = busy[i] &&
                       (s1_valid[i] || rob_ready[s1_tag[i]]) &&
                       (s2_valid[i] || rob_ready[s2_tag[i]]);
        end
    end

    // Pick the oldest ready entry; ages are unique so no tie-break is needed
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!sel_found || age[i] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age[i];
            end
        end
    end

    assign in_ready    = any_free;
    assign issue_valid = sel_found && !flush;
    assign fire        = issue_valid && issue_ready;
    assign alloc       = in_valid && in_ready && !flush;
    assign empty       = (occupancy == '0);

    // Drive the selected entry to the FU, bypassing operands arriving this cycle
    always_comb begin
        issue_op   = '0;
        issue_src1 = '0;
        issue_src2 = '0;
        issue_tag  = '0;
        if (issue_valid) begin
            issue_op   = op[sel_idx];
            issue_tag  = rd_tag[sel_idx];
            issue_src1 = s1_valid[sel_idx] ? s1_data[sel_idx] : rob_word[s1_tag[sel_idx]];
            issue_src2 = s2_valid[sel_idx] ? s2_data[sel_idx] : rob_word[s2_tag[sel_idx]];
        end
    end

    // Entry storage: allocate, snoop, issue-clear and age bookkeeping
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                busy[i]     <= 1'b0;
                op[i]       <= '0;
                rd_tag[i]   <= '0;
                s1_valid[i] <= 1'b0;
                s1_tag[i]   <= '0;
                s1_data[i]  <= '0;
                s2_valid[i] <= 1'b0;
                s2_tag[i]   <= '0;
                s2_data[i]  <= '0;
                age[i]      <= '0;
            end else if (flush) begin
                busy[i] <= 1'b0;
                age[i]  <= '0;
            end else if (fire && sel_idx == IDX_W'(i)) begin
                busy[i] <= 1'b0;
                age[i]  <= '0;
            end else if (alloc && alloc_idx == IDX_W'(i)) begin
                busy[i]     <= 1'b1;
                op[i]       <= in_op;
                rd_tag[i]   <= in_rd_tag;
                age[i]      <= '0;
                s1_tag[i]   <= in_src1_tag;
                s1_valid[i] <= in_src1_valid || rob_ready[in_src1_tag];
                s1_data[i]  <= in_src1_valid ? in_src1_data : rob_word[in_src1_tag];
                s2_tag[i]   <= in_src2_tag;
                s2_valid[i] <= in_src2_valid || rob_ready[in_src2_tag];
                s2_data[i]  <= in_src2_valid ? in_src2_data : rob_word[in_src2_tag];
            end else if (busy[i]) begin
                if (!s1_valid[i] && rob_ready[s1_tag[i]]) begin
                    s1_valid[i] <= 1'b1;
                    s1_data[i]  <= rob_word[s1_tag[i]];
                end
                if (!s2_valid[i] && rob_ready[s2_tag[i]]) begin
                    s2_valid[i] <= 1'b1;
                    s2_data[i]  <= rob_word[s2_tag[i]];
                end
                age[i] <= age[i]
                        + (alloc ? AGE_W'(1) : AGE_W'(0))
                        - ((fire && age[i] > sel_age) ? AGE_W'(1) : AGE_W'(0));
            end
        end
    end

    // Occupancy tracks net allocations minus issues
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else begin
            case ({alloc, fire})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb_rs_issue_queue: directed self-checking bench for rs_issue_queue
// (DEPTH=4, TAG_W=3, DATA_W=32, OP_W=7).
module tb_rs_issue_queue;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [6:0]   in_op;
    logic         in_src1_valid;
    logic         in_src2_valid;
    logic [2:0]   in_src1_tag;
    logic [2:0]   in_src2_tag;
    logic [31:0]  in_src1_data;
    logic [31:0]  in_src2_data;
    logic [2:0]   in_rd_tag;
    logic [7:0]   rob_ready;
    logic [255:0] rob_data;
    logic         issue_valid;
    logic         issue_ready;
    logic [6:0]   issue_op;
    logic [31:0]  issue_src1;
    logic [31:0]  issue_src2;
    logic [2:0]   issue_tag;
    logic [2:0]   occupancy;
    logic         empty;

    int pass_count  = 0;
    int total_count = 0;

    rs_issue_queue #(.DEPTH(4), .TAG_W(3), .DATA_W(32), .OP_W(7)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1_valid(in_src1_valid), .in_src2_valid(in_src2_valid),
        .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag),
        .in_src1_data(in_src1_data), .in_src2_data(in_src2_data),
        .in_rd_tag(in_rd_tag), .rob_ready(rob_ready), .rob_data(rob_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_src1(issue_src1), .issue_src2(issue_src2),
        .issue_tag(issue_tag), .occupancy(occupancy), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        else
            pass_count++;
    endtask

    task automatic applyStimulus(input logic [6:0] op,
                                 input logic v1, input logic [2:0] t1, input logic [31:0] d1,
                                 input logic v2, input logic [2:0] t2, input logic [31:0] d2,
                                 input logic [2:0] rd);
        in_valid      = 1'b1;
        in_op         = op;
        in_src1_valid = v1;
        in_src1_tag   = t1;
        in_src1_data  = d1;
        in_src2_valid = v2;
        in_src2_tag   = t2;
        in_src2_data  = d2;
        in_rd_tag     = rd;
    endtask

    task automatic idleInputs();
        in_valid      = 1'b0;
        in_op         = '0;
        in_src1_valid = 1'b0;
        in_src1_tag   = '0;
        in_src1_data  = '0;
        in_src2_valid = 1'b0;
        in_src2_tag   = '0;
        in_src2_data  = '0;
        in_rd_tag     = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        issue_ready = 1'b0;
        rob_ready   = '0;
        rob_data    = '0;
        idleInputs();
        step();
        step();
        rst = 1'b0;
        settle();

        $display("[TB] reset state");
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_empty", 64'(empty), 64'd1);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_issue_valid", 64'(issue_valid), 64'd0);
        checkOutput("rst_issue_op", 64'(issue_op), 64'd0);
        checkOutput("rst_issue_src1", 64'(issue_src1), 64'd0);
        checkOutput("rst_issue_tag", 64'(issue_tag), 64'd0);

        $display("[TB] ready at dispatch");
        applyStimulus(7'h11, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd7, 3'd2);
        settle();
        checkOutput("rad_not_eligible_yet", 64'(issue_valid), 64'd0);
        step();
        idleInputs();
        settle();
        checkOutput("rad_occupancy", 64'(occupancy), 64'd1);
        checkOutput("rad_empty", 64'(empty), 64'd0);
        checkOutput("rad_issue_valid", 64'(issue_valid), 64'd1);
        checkOutput("rad_src1", 64'(issue_src1), 64'd5);
        checkOutput("rad_src2", 64'(issue_src2), 64'd7);
        checkOutput("rad_tag", 64'(issue_tag), 64'd2);
        checkOutput("rad_op", 64'(issue_op), 64'h11);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        settle();
        checkOutput("rad_drained_occ", 64'(occupancy), 64'd0);
        checkOutput("rad_drained_empty", 64'(empty), 64'd1);
        checkOutput("rad_drained_valid", 64'(issue_valid), 64'd0);

        $display("[TB] snoop and bypass");
        applyStimulus(7'h22, 1'b0, 3'd3, 32'd0, 1'b1, 3'd0, 32'd9, 3'd4);
        step();
        idleInputs();
        step();
        step();
        step();
        settle();
        checkOutput("snp_waiting", 64'(issue_valid), 64'd0);
        rob_ready[3] = 1'b1;
        rob_data[3*32 +: 32] = 32'h1234;
        settle();
        checkOutput("snp_bypass_valid", 64'(issue_valid), 64'd1);
        checkOutput("snp_bypass_src1", 64'(issue_src1), 64'h1234);
        checkOutput("snp_bypass_src2", 64'(issue_src2), 64'd9);
        step();
        rob_ready[3] = 1'b0;
        rob_data[3*32 +: 32] = 32'hDEAD;
        settle();
        checkOutput("snp_latched_valid", 64'(issue_valid), 64'd1);
        checkOutput("snp_latched_src1", 64'(issue_src1), 64'h1234);
        issue_ready = 1'b1;
        settle();
        checkOutput("snp_latched_tag", 64'(issue_tag), 64'd4);
        step();
        issue_ready = 1'b0;
        settle();
        checkOutput("snp_drained_occ", 64'(occupancy), 64'd0);

        $display("[TB] oldest first");
        applyStimulus(7'h01, 1'b0, 3'd1, 32'd0, 1'b1, 3'd0, 32'd1, 3'd5);
        step();
        applyStimulus(7'h02, 1'b0, 3'd1, 32'd0, 1'b1, 3'd0, 32'd2, 3'd6);
        step();
        applyStimulus(7'h03, 1'b0, 3'd1, 32'd0, 1'b1, 3'd0, 32'd3, 3'd7);
        step();
        idleInputs();
        settle();
        checkOutput("old_occupancy", 64'(occupancy), 64'd3);
        checkOutput("old_waiting", 64'(issue_valid), 64'd0);
        rob_ready[1] = 1'b1;
        rob_data[1*32 +: 32] = 32'h100;
        issue_ready = 1'b1;
        settle();
        checkOutput("old_first_tag", 64'(issue_tag), 64'd5);
        checkOutput("old_first_src1", 64'(issue_src1), 64'h100);
        step();
        checkOutput("old_second_tag", 64'(issue_tag), 64'd6);
        step();
        checkOutput("old_third_tag", 64'(issue_tag), 64'd7);
        checkOutput("old_third_op", 64'(issue_op), 64'h03);
        step();
        issue_ready = 1'b0;
        rob_ready   = '0;
        settle();
        checkOutput("old_drained_occ", 64'(occupancy), 64'd0);

        $display("[TB] full and simultaneous");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(7'(8'h40 + k), 1'b1, 3'd0, 32'(10 + k), 1'b1, 3'd0, 32'd0, 3'(k));
            step();
        end
        applyStimulus(7'h55, 1'b1, 3'd0, 32'd55, 1'b1, 3'd0, 32'd0, 3'd5);
        settle();
        checkOutput("full_occupancy", 64'(occupancy), 64'd4);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        step();
        settle();
        checkOutput("full_ignored_occ", 64'(occupancy), 64'd4);
        checkOutput("full_oldest_tag", 64'(issue_tag), 64'd0);
        checkOutput("full_oldest_src1", 64'(issue_src1), 64'd10);
        applyStimulus(7'h66, 1'b1, 3'd0, 32'd66, 1'b1, 3'd0, 32'd0, 3'd6);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        settle();
        checkOutput("sim_not_accepted_occ", 64'(occupancy), 64'd3);
        checkOutput("sim_in_ready", 64'(in_ready), 64'd1);
        step();
        idleInputs();
        settle();
        checkOutput("sim_accepted_occ", 64'(occupancy), 64'd4);
        issue_ready = 1'b1;
        settle();
        checkOutput("drain_tag_a", 64'(issue_tag), 64'd1);
        step();
        checkOutput("drain_tag_b", 64'(issue_tag), 64'd2);
        step();
        checkOutput("drain_tag_c", 64'(issue_tag), 64'd3);
        step();
        checkOutput("drain_tag_d", 64'(issue_tag), 64'd6);
        checkOutput("drain_src1_d", 64'(issue_src1), 64'd66);
        step();
        issue_ready = 1'b0;
        settle();
        checkOutput("drain_occ", 64'(occupancy), 64'd0);
        checkOutput("drain_valid", 64'(issue_valid), 64'd0);

        $display("[TB] allocate and issue on the same edge");
        applyStimulus(7'h71, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd0, 3'd1);
        step();
        applyStimulus(7'h72, 1'b1, 3'd0, 32'd2, 1'b1, 3'd0, 32'd0, 3'd2);
        step();
        applyStimulus(7'h73, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 32'd0, 3'd3);
        issue_ready = 1'b1;
        settle();
        checkOutput("ai_issue_first", 64'(issue_tag), 64'd1);
        step();
        idleInputs();
        issue_ready = 1'b0;
        settle();
        checkOutput("ai_occupancy", 64'(occupancy), 64'd2);
        checkOutput("ai_next_tag", 64'(issue_tag), 64'd2);
        issue_ready = 1'b1;
        step();
        checkOutput("ai_last_tag", 64'(issue_tag), 64'd3);
        step();
        issue_ready = 1'b0;
        settle();
        checkOutput("ai_drained_occ", 64'(occupancy), 64'd0);

        $display("[TB] flush");
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(7'(k), 1'b1, 3'd0, 32'(k), 1'b1, 3'd0, 32'd0, 3'(k));
            step();
        end
        idleInputs();
        settle();
        checkOutput("fl_before_valid", 64'(issue_valid), 64'd1);
        checkOutput("fl_before_occ", 64'(occupancy), 64'd3);
        flush = 1'b1;
        applyStimulus(7'h7F, 1'b1, 3'd0, 32'd99, 1'b1, 3'd0, 32'd0, 3'd7);
        issue_ready = 1'b1;
        settle();
        checkOutput("fl_issue_valid", 64'(issue_valid), 64'd0);
        checkOutput("fl_issue_tag_zero", 64'(issue_tag), 64'd0);
        step();
        flush = 1'b0;
        idleInputs();
        settle();
        checkOutput("fl_occupancy", 64'(occupancy), 64'd0);
        checkOutput("fl_empty", 64'(empty), 64'd1);
        checkOutput("fl_in_ready", 64'(in_ready), 64'd1);
        checkOutput("fl_after_valid", 64'(issue_valid), 64'd0);
        step();
        step();
        checkOutput("fl_later_valid", 64'(issue_valid), 64'd0);
        issue_ready = 1'b0;

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
